core_lsu: RTL and testbench

//  Load/store unit downstream of core_execution: takes effective address (adder result), store data (rs2) and op,

---
 rtl/core_pkg.sv | 63 ++++++
 rtl/core_lsu_align.sv | 64 ++++++
 rtl/core_lsu.sv | 196 +++++++++++++++++++
 tb/tb_core_lsu.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and helpers for the load/store unit: op encoding, FSM states,
// byte-enable patterns and small decode functions used by the top and the aligner.
package core_pkg;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        SB  = 3'd3,
        LBU = 3'd4,
        LHU = 3'd5,
        SH  = 3'd6,
        SW  = 3'd7
    } lsu_op_t;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Access size of an op; unknown encodings fall back to a full word.
    function automatic lsu_size_t op_size(input lsu_op_t op);
        lsu_size_t sz;
        case (op)
            LB, LBU, SB: sz = SZ_BYTE;
            LH, LHU, SH: sz = SZ_HALF;
            default:     sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic op_is_store(input lsu_op_t op);
        logic st;
        case (op)
            SB, SH, SW: st = 1'b1;
            default:    st = 1'b0;
        endcase
        return st;
    endfunction

    // Halfwords must sit on even addresses, words on multiples of four.
    function automatic logic op_misaligned(input lsu_op_t op, input logic [1:0] off);
        logic mis;
        case (op_size(op))
            SZ_HALF: mis = off[0];
            SZ_WORD: mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Combinational lane logic: store data replication and byte enables on the way
// out, lane selection and sign/zero extension of load data on the way back.
module core_lsu_align
    import core_pkg::*;
(
    input  lsu_op_t     st_op_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    input  lsu_op_t     ld_op_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ld_byte_s;
    logic [15:0] ld_half_s;

    // Store side: replicate the datum into every lane it may land in and
    // enable only the addressed bytes.
    always_comb begin
        st_be_o    = BE_WORD;
        st_wdata_o = st_wdata_i;
        case (op_size(st_op_i))
            SZ_BYTE: begin
                st_be_o    = BE_BYTE << st_off_i;
                st_wdata_o = {4{st_wdata_i[7:0]}};
            end
            SZ_HALF: begin
                st_be_o    = BE_HALF << st_off_i;
                st_wdata_o = {2{st_wdata_i[15:0]}};
            end
            default: begin
                st_be_o    = BE_WORD;
                st_wdata_o = st_wdata_i;
            end
        endcase
    end

    // Load side: pick the addressed lane, then extend according to the op.
    always_comb begin
        ld_byte_s = ld_rdata_i[7:0];
        case (ld_off_i)
            2'd0:    ld_byte_s = ld_rdata_i[7:0];
            2'd1:    ld_byte_s = ld_rdata_i[15:8];
            2'd2:    ld_byte_s = ld_rdata_i[23:16];
            default: ld_byte_s = ld_rdata_i[31:24];
        endcase
        if (ld_off_i[1]) begin
            ld_half_s = ld_rdata_i[31:16];
        end else begin
            ld_half_s = ld_rdata_i[15:0];
        end
        case (ld_op_i)
            LB:      ld_data_o = {{24{ld_byte_s[7]}}, ld_byte_s};
            LBU:     ld_data_o = {24'd0, ld_byte_s};
            LH:      ld_data_o = {{16{ld_half_s[15]}}, ld_half_s};
            LHU:     ld_data_o = {16'd0, ld_half_s};
            default: ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/core_lsu.sv
// Load/store unit: accepts one access from execution, runs it over the
// req/grnt data-memory port and returns extended load data for write-back.
// Only one access is in flight; lsu_ready_o is high only in IDLE.
module core_lsu
    import core_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RD_ADDR_W = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 lsu_valid_i,
    output logic                 lsu_ready_o,
    input  logic [2:0]           lsu_op_i,
    input  logic [XLEN-1:0]      lsu_addr_i,
    input  logic [XLEN-1:0]      lsu_wdata_i,
    input  logic [RD_ADDR_W-1:0] lsu_rd_addr_i,
    output logic                 data_mem_req_o,
    input  logic                 data_mem_grnt_i,
    output logic [XLEN-1:0]      data_mem_addr_o,
    output logic [XLEN-1:0]      data_mem_wdata_o,
    output logic [3:0]           data_mem_be_o,
    output logic                 data_mem_wen_o,
    output logic                 data_mem_ren_o,
    input  logic [XLEN-1:0]      data_mem_rdata_i,
    input  logic                 data_mem_rvalid_i,
    output logic                 wb_valid_o,
    output logic [RD_ADDR_W-1:0] wb_rd_addr_o,
    output logic [XLEN-1:0]      wb_data_o,
    output logic                 store_done_o,
    output logic                 exc_misaligned_o,
    output logic [XLEN-1:0]      exc_addr_o
);

    lsu_state_t state_q, state_d;

    lsu_op_t                op_in_s;
    logic                   accept_s;
    logic                   misal_s;
    logic                   take_grnt_s;
    logic                   take_rdata_s;
    logic [3:0]             st_be_s;
    logic [31:0]            st_wdata_s;
    logic [31:0]            ld_data_s;

    lsu_op_t                op_q;
    logic [1:0]             off_q;
    logic [RD_ADDR_W-1:0]   rd_q;
    logic                   req_q;
    logic                   wen_q;
    logic                   ren_q;
    logic [XLEN-1:0]        mem_addr_q;
    logic [XLEN-1:0]        mem_wdata_q;
    logic [3:0]             mem_be_q;
    logic                   wb_valid_q;
    logic [RD_ADDR_W-1:0]   wb_rd_q;
    logic [XLEN-1:0]        wb_data_q;
    logic                   store_done_q;
    logic                   exc_q;
    logic [XLEN-1:0]        exc_addr_q;

    assign op_in_s = lsu_op_t'(lsu_op_i);

    core_lsu_align u_align (
        .st_op_i    (op_in_s),
        .st_off_i   (lsu_addr_i[1:0]),
        .st_wdata_i (lsu_wdata_i[31:0]),
        .st_be_o    (st_be_s),
        .st_wdata_o (st_wdata_s),
        .ld_op_i    (op_q),
        .ld_off_i   (off_q),
        .ld_rdata_i (data_mem_rdata_i[31:0]),
        .ld_data_o  (ld_data_s)
    );

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= LSU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and event decode; grnt outside REQ and rvalid outside WAIT fall through unused.
    always_comb begin
        state_d      = state_q;
        accept_s     = 1'b0;
        misal_s      = 1'b0;
        take_grnt_s  = 1'b0;
        take_rdata_s = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (lsu_valid_i) begin
                    if (op_misaligned(op_in_s, lsu_addr_i[1:0])) begin
                        misal_s = 1'b1;
                    end else begin
                        accept_s = 1'b1;
                        state_d  = LSU_REQ;
                    end
                end else begin
                    state_d = LSU_IDLE;
                end
            end
            LSU_REQ: begin
                if (data_mem_grnt_i) begin
                    take_grnt_s = 1'b1;
                    if (op_is_store(op_q)) begin
                        state_d = LSU_IDLE;
                    end else begin
                        state_d = LSU_WAIT;
                    end
                end else begin
                    state_d = LSU_REQ;
                end
            end
            LSU_WAIT: begin
                if (data_mem_rvalid_i) begin
                    take_rdata_s = 1'b1;
                    state_d      = LSU_IDLE;
                end else begin
                    state_d = LSU_WAIT;
                end
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    // Datapath registers: latch the request, drive the memory port, and produce the one-cycle result pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q         <= LB;
            off_q        <= 2'd0;
            rd_q         <= '0;
            req_q        <= 1'b0;
            wen_q        <= 1'b0;
            ren_q        <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= 4'd0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            store_done_q <= 1'b0;
            exc_q        <= 1'b0;
            exc_addr_q   <= '0;
        end else begin
            store_done_q <= 1'b0;
            exc_q        <= 1'b0;
            wb_valid_q   <= 1'b0;
            if (accept_s) begin
                op_q        <= op_in_s;
                off_q       <= lsu_addr_i[1:0];
                rd_q        <= lsu_rd_addr_i;
                req_q       <= 1'b1;
                wen_q       <= op_is_store(op_in_s);
                ren_q       <= ~op_is_store(op_in_s);
                mem_addr_q  <= {lsu_addr_i[XLEN-1:2], 2'b00};
                mem_wdata_q <= st_wdata_s;
                mem_be_q    <= st_be_s;
            end
            if (misal_s) begin
                exc_q      <= 1'b1;
                exc_addr_q <= lsu_addr_i;
            end
            if (take_grnt_s) begin
                req_q        <= 1'b0;
                wen_q        <= 1'b0;
                ren_q        <= 1'b0;
                store_done_q <= op_is_store(op_q);
            end
            if (take_rdata_s) begin
                wb_valid_q <= 1'b1;
                wb_data_q  <= ld_data_s;
                wb_rd_q    <= rd_q;
            end
        end
    end

    assign lsu_ready_o      = (state_q == LSU_IDLE);
    assign data_mem_req_o   = req_q;
    assign data_mem_addr_o  = mem_addr_q;
    assign data_mem_wdata_o = mem_wdata_q;
    assign data_mem_be_o    = mem_be_q;
    assign data_mem_wen_o   = wen_q;
    assign data_mem_ren_o   = ren_q;
    assign wb_valid_o       = wb_valid_q;
    assign wb_rd_addr_o     = wb_rd_q;
    assign wb_data_o        = wb_data_q;
    assign store_done_o     = store_done_q;
    assign exc_misaligned_o = exc_q;
    assign exc_addr_o       = exc_addr_q;

endmodule

// File: tb/tb_core_lsu.sv
// Directed bench for core_lsu: inputs change and outputs are sampled on the
// falling clock edge, away from the rising edge the DUT uses.
module tb_core_lsu;
    import core_pkg::*;

    logic        clk;
    logic        rst;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [2:0]  lsu_op;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [4:0]  lsu_rd;
    logic        mem_req;
    logic        mem_grnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_wen;
    logic        mem_ren;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        store_done;
    logic        exc_mis;
    logic [31:0] exc_addr;

    int n_total;
    int n_bad;

    core_lsu #(.XLEN(32), .RD_ADDR_W(5)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .lsu_valid_i       (lsu_valid),
        .lsu_ready_o       (lsu_ready),
        .lsu_op_i          (lsu_op),
        .lsu_addr_i        (lsu_addr),
        .lsu_wdata_i       (lsu_wdata),
        .lsu_rd_addr_i     (lsu_rd),
        .data_mem_req_o    (mem_req),
        .data_mem_grnt_i   (mem_grnt),
        .data_mem_addr_o   (mem_addr),
        .data_mem_wdata_o  (mem_wdata),
        .data_mem_be_o     (mem_be),
        .data_mem_wen_o    (mem_wen),
        .data_mem_ren_o    (mem_ren),
        .data_mem_rdata_i  (mem_rdata),
        .data_mem_rvalid_i (mem_rvalid),
        .wb_valid_o        (wb_valid),
        .wb_rd_addr_o      (wb_rd),
        .wb_data_o         (wb_data),
        .store_done_o      (store_done),
        .exc_misaligned_o  (exc_mis),
        .exc_addr_o        (exc_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total = n_total + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a request for one cycle; returns at the falling edge of the REQ cycle.
    task automatic issue(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
        lsu_valid = 1'b1;
        lsu_op    = op;
        lsu_addr  = addr;
        lsu_wdata = wdata;
        lsu_rd    = rd;
        @(negedge clk);
        lsu_valid = 1'b0;
    endtask

    task automatic do_store(input string tag, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        issue(op, addr, wdata, 5'd0);
        check_eq({tag, ".req"},   32'(mem_req), 32'd1);
        check_eq({tag, ".wen"},   32'(mem_wen), 32'd1);
        check_eq({tag, ".ren"},   32'(mem_ren), 32'd0);
        check_eq({tag, ".addr"},  mem_addr, exp_addr);
        check_eq({tag, ".be"},    32'(mem_be), 32'(exp_be));
        check_eq({tag, ".wdata"}, mem_wdata, exp_wdata);
        check_eq({tag, ".busy"},  32'(lsu_ready), 32'd0);
        mem_grnt = 1'b1;
        @(negedge clk);
        mem_grnt = 1'b0;
        check_eq({tag, ".done"},  32'(store_done), 32'd1);
        check_eq({tag, ".reqlo"}, 32'(mem_req), 32'd0);
        check_eq({tag, ".rdy"},   32'(lsu_ready), 32'd1);
        @(negedge clk);
        check_eq({tag, ".done1"}, 32'(store_done), 32'd0);
    endtask

    // Minimum-latency load; returns on the write-back pulse with the LSU idle again.
    task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [4:0] rd, input logic [31:0] rdata,
                           input logic [31:0] exp_data, input logic [3:0] exp_be);
        issue(op, addr, 32'd0, rd);
        check_eq({tag, ".ren"}, 32'(mem_ren), 32'd1);
        check_eq({tag, ".wen"}, 32'(mem_wen), 32'd0);
        check_eq({tag, ".be"},  32'(mem_be), 32'(exp_be));
        check_eq({tag, ".addr"}, mem_addr, {addr[31:2], 2'b00});
        mem_grnt = 1'b1;
        @(negedge clk);
        mem_grnt   = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        check_eq({tag, ".wbearly"}, 32'(wb_valid), 32'd0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        check_eq({tag, ".wbv"},  32'(wb_valid), 32'd1);
        check_eq({tag, ".data"}, wb_data, exp_data);
        check_eq({tag, ".rd"},   32'(wb_rd), 32'(rd));
        check_eq({tag, ".rdy"},  32'(lsu_ready), 32'd1);
    endtask

    task automatic do_misaligned(input string tag, input logic [2:0] op, input logic [31:0] addr);
        issue(op, addr, 32'h1234_5678, 5'd3);
        check_eq({tag, ".exc"},   32'(exc_mis), 32'd1);
        check_eq({tag, ".eaddr"}, exc_addr, addr);
        check_eq({tag, ".noreq"}, 32'(mem_req), 32'd0);
        check_eq({tag, ".rdy"},   32'(lsu_ready), 32'd1);
        @(negedge clk);
        check_eq({tag, ".exc1"},  32'(exc_mis), 32'd0);
        check_eq({tag, ".noreq1"}, 32'(mem_req), 32'd0);
    endtask

    initial begin
        n_total    = 0;
        n_bad      = 0;
        rst        = 1'b1;
        lsu_valid  = 1'b0;
        lsu_op     = 3'd0;
        lsu_addr   = 32'd0;
        lsu_wdata  = 32'd0;
        lsu_rd     = 5'd0;
        mem_grnt   = 1'b0;
        mem_rdata  = 32'd0;
        mem_rvalid = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check_eq("rst.ready", 32'(lsu_ready), 32'd1);
        check_eq("rst.req",   32'(mem_req), 32'd0);
        check_eq("rst.addr",  mem_addr, 32'd0);
        check_eq("rst.be",    32'(mem_be), 32'd0);
        check_eq("rst.wbv",   32'(wb_valid), 32'd0);
        check_eq("rst.wbd",   wb_data, 32'd0);
        check_eq("rst.exca",  exc_addr, 32'd0);
        check_eq("rst.done",  32'(store_done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // stores
        do_store("sw",  SW, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
        do_store("sb",  SB, 32'h0000_0103, 32'h0000_00A5, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5);
        do_store("sh",  SH, 32'h0000_0206, 32'h0000_C3D2, 32'h0000_0204, 4'b1100, 32'hC3D2_C3D2);

        // loads back to back at full rate
        do_load("lb2",  LB,  32'h0000_0102, 5'd5,  32'h8011_2233, 32'h0000_0011, 4'b0100);
        do_load("lb3",  LB,  32'h0000_0103, 5'd6,  32'h8011_2233, 32'hFFFF_FF80, 4'b1000);
        do_load("lbu3", LBU, 32'h0000_0103, 5'd7,  32'h8011_2233, 32'h0000_0080, 4'b1000);
        do_load("lh2",  LH,  32'h0000_0102, 5'd8,  32'h8011_2233, 32'hFFFF_8011, 4'b1100);
        do_load("lhu0", LHU, 32'h0000_0100, 5'd9,  32'h8011_F233, 32'h0000_F233, 4'b0011);
        do_load("lw",   LW,  32'h0000_0104, 5'd31, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111);
        @(negedge clk);
        check_eq("lw.wb1", 32'(wb_valid), 32'd0);

        // misaligned accesses
        do_misaligned("mis_lw", LW, 32'h0000_0102);
        do_misaligned("mis_lh", LH, 32'h0000_0101);
        do_misaligned("mis_sw", SW, 32'h0000_0201);

        // grant withheld, rvalid during REQ ignored, late rvalid
        issue(LW, 32'h0000_0304, 32'd0, 5'd12);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        for (int i = 0; i < 5; i++) begin
            check_eq("hold.req",  32'(mem_req), 32'd1);
            check_eq("hold.addr", mem_addr, 32'h0000_0304);
            check_eq("hold.be",   32'(mem_be), 32'hF);
            check_eq("hold.rdy",  32'(lsu_ready), 32'd0);
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        check_eq("hold.wbv", 32'(wb_valid), 32'd0);
        mem_grnt = 1'b1;
        @(negedge clk);
        mem_grnt = 1'b0;
        check_eq("hold.reqlo", 32'(mem_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check_eq("late.wbv", 32'(wb_valid), 32'd0);
            check_eq("late.rdy", 32'(lsu_ready), 32'd0);
            @(negedge clk);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check_eq("late.wbv1", 32'(wb_valid), 32'd1);
        check_eq("late.data", wb_data, 32'h1234_5678);
        check_eq("late.rd",   32'(wb_rd), 32'd12);
        @(negedge clk);
        check_eq("late.wbv0", 32'(wb_valid), 32'd0);

        // reset while waiting for load data, then a late rvalid
        issue(LW, 32'h0000_0108, 32'd0, 5'd7);
        mem_grnt = 1'b1;
        @(negedge clk);
        mem_grnt = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        check_eq("rstw.rdy", 32'(lsu_ready), 32'd1);
        check_eq("rstw.req", 32'(mem_req), 32'd0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        check_eq("rstw.wbv", 32'(wb_valid), 32'd0);
        check_eq("rstw.wbd", wb_data, 32'd0);
        check_eq("rstw.rdy1", 32'(lsu_ready), 32'd1);
        @(negedge clk);
        check_eq("rstw.wbv1", 32'(wb_valid), 32'd0);

        // normal operation after reset
        do_load("post", LB, 32'h0000_0101, 5'd2, 32'h0000_7F00, 32'h0000_007F, 4'b0010);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
